// File: rtl/tx_seq_ack_tracker.sv
// PCIe DLL TX sequence/ack tracker: owns NEXT_TRANSMIT_SEQ, ACKD_SEQ, REPLAY_NUM and replay timer.
// Optional feature macro DLLP_ERR_CNT_EN adds the saturating dllp_err_cnt output.
module tx_seq_ack_tracker #(
    parameter int unsigned REPLAY_TIMEOUT = 711,
    parameter int unsigned TIMER_W        = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DL_Down,
    input  logic        tlp_sent,
    input  logic        dllp_valid,
    input  logic        dllp_is_nak,
    input  logic [11:0] dllp_seq,
    output logic [11:0] next_tx_seq,
    output logic [11:0] ackd_seq,
    output logic [11:0] outstanding,
    output logic        tx_stall,
    output logic        purge_valid,
    output logic [11:0] purge_count,
    output logic        replay_start,
    input  logic        replay_done,
    output logic [1:0]  replay_num,
    output logic        retrain_req,
    output logic        dllp_err
`ifdef DLLP_ERR_CNT_EN
    ,
    output logic [7:0]  dllp_err_cnt
`endif
);

    typedef enum logic [0:0] {StIdle, StReplay} state_e;

    state_e             r_state, w_state_d;
    logic [11:0]        r_next_tx_seq, w_next_tx_seq_d;
    logic [11:0]        r_ackd_seq, w_ackd_seq_d;
    logic [1:0]         r_replay_num, w_replay_num_d, w_replay_base;
    logic [TIMER_W-1:0] r_timer, w_timer_d;
    logic               r_purge_valid;
    logic [11:0]        r_purge_count, w_purge_count_d;
    logic               r_replay_start;
    logic               r_retrain_req, w_retrain_d;
    logic               r_dllp_err;

    logic [11:0] w_outstanding;
    logic [11:0] w_d;
    logic        w_stall;
    logic        w_tlp_acc;
    logic        w_in_range;
    logic        w_err;
    logic        w_fwd;
    logic        w_nak_init;
    logic        w_timer_live;
    logic        w_expire;
    logic        w_init;

    assign w_outstanding = r_next_tx_seq - r_ackd_seq - 12'd1;
    // Outstanding never exceeds 2048, so bit 11 alone flags the window limit.
    assign w_stall       = w_outstanding[11] | (r_state == StReplay);
    assign w_tlp_acc     = tlp_sent & ~w_stall;

    assign w_d           = dllp_seq - r_ackd_seq;
    assign w_in_range    = (w_d <= w_outstanding);
    assign w_err         = dllp_valid & ~w_in_range;
    assign w_fwd         = dllp_valid & w_in_range & (w_d != 12'd0);
    // Within range, o-d > 0 is simply d != o.
    assign w_nak_init    = dllp_valid & dllp_is_nak & w_in_range & (r_state == StIdle)
                         & (w_d != w_outstanding);

    assign w_timer_live  = (r_state == StIdle) & (w_outstanding != 12'd0);
    assign w_expire      = w_timer_live & (r_timer == TIMER_W'(REPLAY_TIMEOUT - 1)) & ~w_fwd;
    assign w_init        = w_nak_init | w_expire;

    always_comb begin
        w_state_d       = r_state;
        w_next_tx_seq_d = r_next_tx_seq + {11'd0, w_tlp_acc};
        w_ackd_seq_d    = r_ackd_seq;
        w_purge_count_d = 12'd0;
        w_timer_d       = '0;
        w_retrain_d     = 1'b0;
        w_replay_base   = r_replay_num;
        w_replay_num_d  = r_replay_num;

        if (w_fwd) begin
            w_ackd_seq_d    = dllp_seq;
            w_purge_count_d = w_d;
            w_replay_base   = 2'd0;
            w_replay_num_d  = 2'd0;
        end

        if (w_init) begin
            if (w_replay_base == 2'd3) begin
                w_replay_num_d = 2'd0;
                w_retrain_d    = 1'b1;
            end else begin
                w_replay_num_d = w_replay_base + 2'd1;
            end
        end

        case (r_state)
            StIdle: begin
                if (w_init) begin
                    w_state_d = StReplay;
                end
            end
            StReplay: begin
                if (replay_done) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Timer counts only while live; any restart, initiation or replay returns it to zero.
        if (w_timer_live && !w_init && !w_fwd) begin
            w_timer_d = r_timer + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || DL_Down) begin
            r_state        <= StIdle;
            r_next_tx_seq  <= 12'd0;
            r_ackd_seq     <= 12'hFFF;
            r_replay_num   <= 2'd0;
            r_timer        <= '0;
            r_purge_valid  <= 1'b0;
            r_purge_count  <= 12'd0;
            r_replay_start <= 1'b0;
            r_retrain_req  <= 1'b0;
            r_dllp_err     <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_next_tx_seq  <= w_next_tx_seq_d;
            r_ackd_seq     <= w_ackd_seq_d;
            r_replay_num   <= w_replay_num_d;
            r_timer        <= w_timer_d;
            r_purge_valid  <= w_fwd;
            r_purge_count  <= w_purge_count_d;
            r_replay_start <= w_init;
            r_retrain_req  <= w_retrain_d;
            r_dllp_err     <= w_err;
        end
    end

`ifdef DLLP_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst || DL_Down) begin
            r_err_cnt <= 8'd0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign dllp_err_cnt = r_err_cnt;
`endif

    assign next_tx_seq  = r_next_tx_seq;
    assign ackd_seq     = r_ackd_seq;
    assign outstanding  = w_outstanding;
    assign tx_stall     = w_stall;
    assign purge_valid  = r_purge_valid;
    assign purge_count  = r_purge_count;
    assign replay_start = r_replay_start;
    assign replay_num   = r_replay_num;
    assign retrain_req  = r_retrain_req;
    assign dllp_err     = r_dllp_err;

endmodule

// File: tb/tb_tx_seq_ack_tracker.sv
// Scoreboard bench for tx_seq_ack_tracker: directed test-plan phases then randomized traffic,
// checked against a sequence-arithmetic model with an absolute-cycle replay deadline.
module tb_tx_seq_ack_tracker;

    localparam int unsigned TO = 24;
    localparam int unsigned TW = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        DL_Down = 1'b0;
    logic        tlp_sent = 1'b0;
    logic        dllp_valid = 1'b0;
    logic        dllp_is_nak = 1'b0;
    logic [11:0] dllp_seq = 12'd0;
    logic        replay_done = 1'b0;
    logic [11:0] next_tx_seq, ackd_seq, outstanding, purge_count;
    logic        tx_stall, purge_valid, replay_start, retrain_req, dllp_err;
    logic [1:0]  replay_num;
`ifdef DLLP_ERR_CNT_EN
    logic [7:0]  dllp_err_cnt;
`endif

    tx_seq_ack_tracker #(.REPLAY_TIMEOUT(TO), .TIMER_W(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .DL_Down      (DL_Down),
        .tlp_sent     (tlp_sent),
        .dllp_valid   (dllp_valid),
        .dllp_is_nak  (dllp_is_nak),
        .dllp_seq     (dllp_seq),
        .next_tx_seq  (next_tx_seq),
        .ackd_seq     (ackd_seq),
        .outstanding  (outstanding),
        .tx_stall     (tx_stall),
        .purge_valid  (purge_valid),
        .purge_count  (purge_count),
        .replay_start (replay_start),
        .replay_done  (replay_done),
        .replay_num   (replay_num),
        .retrain_req  (retrain_req),
        .dllp_err     (dllp_err)
`ifdef DLLP_ERR_CNT_EN
        ,
        .dllp_err_cnt (dllp_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int nxt; int ackd; int outs; int stall; int rnum;
        int pv; int pc; int rs; int rr; int de; int cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: plain sequence arithmetic, replay timer kept as an absolute deadline cycle.
    int m_nxt = 0, m_ackd = 4095, m_rnum = 0, m_cnt = 0, m_dead = -1, m_cyc = 0;
    bit m_rep = 1'b0;

    function automatic int m_outs();
        return (m_nxt - m_ackd - 1) & 4095;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit dl, input bit tlp, input bit dv, input bit nak,
                        input int seq, input bit done);
        exp_t e;
        int   o, d, acc;
        bit   err, valid, fwd, expire, ninit, init, rep_old;
        @(negedge clk);
        rst = r; DL_Down = dl; tlp_sent = tlp; dllp_valid = dv; dllp_is_nak = nak;
        dllp_seq = 12'(seq); replay_done = done;
        e = '{default: 0};
        if (r || dl) begin
            m_nxt = 0; m_ackd = 4095; m_rnum = 0; m_rep = 1'b0; m_dead = -1; m_cnt = 0;
        end else begin
            o       = m_outs();
            acc     = (tlp && !(o >= 2048 || m_rep)) ? 1 : 0;
            d       = (seq - m_ackd) & 4095;
            err     = dv && (d > o);
            valid   = dv && (d <= o);
            fwd     = valid && (d != 0);
            expire  = !m_rep && (o > 0) && (m_dead == m_cyc) && !fwd;
            ninit   = valid && nak && !m_rep && (o - d > 0);
            init    = ninit || expire;
            rep_old = m_rep;
            m_nxt   = (m_nxt + acc) & 4095;
            if (fwd) begin
                m_ackd = seq & 4095; m_rnum = 0; e.pv = 1; e.pc = d;
            end
            if (init) begin
                e.rs = 1;
                m_rep = 1'b1;
                if (m_rnum == 3) begin e.rr = 1; m_rnum = 0; end
                else m_rnum++;
            end else if (m_rep && done) begin
                m_rep = 1'b0;
            end
            if (m_rep || m_outs() == 0) m_dead = -1;
            else if (fwd || (rep_old && done) || m_dead < 0) m_dead = m_cyc + TO;
            if (err) begin
                e.de = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        m_cyc++;
        e.nxt = m_nxt; e.ackd = m_ackd; e.outs = m_outs();
        e.stall = (e.outs >= 2048 || m_rep) ? 1 : 0;
        e.rnum = m_rnum; e.cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, m_rep);
    endtask

    // Monitor: pops one expectation per cycle in which stimulus was applied.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("next_tx_seq", int'(next_tx_seq), e.nxt);
            chk("ackd_seq", int'(ackd_seq), e.ackd);
            chk("outstanding", int'(outstanding), e.outs);
            chk("tx_stall", int'(tx_stall), e.stall);
            chk("replay_num", int'(replay_num), e.rnum);
            chk("purge_valid", int'(purge_valid), e.pv);
            chk("purge_count", int'(purge_count), e.pc);
            chk("replay_start", int'(replay_start), e.rs);
            chk("retrain_req", int'(retrain_req), e.rr);
            chk("dllp_err", int'(dllp_err), e.de);
`ifdef DLLP_ERR_CNT_EN
            chk("dllp_err_cnt", int'(dllp_err_cnt), e.cnt);
`endif
        end
    end

    initial begin
        int seq;
        // 1: reset
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        // 2: five TLPs then Ack 2
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 2, 0);
        idle(3);
        // 3: preload to 4094 with running Acks, then wrap
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4094; i++) step(0, 0, 1, (i > 0), 0, i - 1, 0);
        step(0, 0, 0, 1, 0, 4093, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(2);
        // 4: fill the 2048 window (replays serviced as they occur), then release
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2100; i++) step(0, 0, 1, 0, 0, 0, m_rep);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, (m_nxt - 1) & 4095, m_rep);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(2);
        // 5: Nak then three timeouts, fourth initiation rolls REPLAY_NUM over
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < int'(TO) + 5 && !m_rep; i++) step(0, 0, 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0, 1);
        end
        idle(2);
        // 6: out-of-range Ack, then DL_Down during replay
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 4, 0);
        step(0, 0, 0, 1, 0, 10, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 4, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) seq = int'($urandom_range(0, 4095));
            else seq = (m_ackd + int'($urandom_range(0, m_outs()))) & 4095;
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 799) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0), seq, ($urandom_range(0, 2) == 0));
        end
        idle(2);
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
